display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_pkg.sv | 18 +
 rtl/hex_to_7seg.sv | 32 +++
 rtl/display_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed seven-segment display scanner.
//   state_e    : scanner phase, SHOW (one digit lit) or BLANK (all dark)
//   NUM_DIGITS : number of multiplexed digits
//   SEG_W      : segment bus width, {g,f,e,d,c,b,a}
//   SEG_OFF    : active-low pattern with every segment dark
package display_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_e;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = '1;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to seven-segment decoder.
//   hex_in  : 4-bit value 0-F
//   seg_out : segments {g,f,e,d,c,b,a}, active-low
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0]       hex_in,
  output logic [SEG_W-1:0] seg_out
);

  always_comb begin
    case (hex_in)
      4'h0:    seg_out = 7'b1000000;
      4'h1:    seg_out = 7'b1111001;
      4'h2:    seg_out = 7'b0100100;
      4'h3:    seg_out = 7'b0110000;
      4'h4:    seg_out = 7'b0011001;
      4'h5:    seg_out = 7'b0010010;
      4'h6:    seg_out = 7'b0000010;
      4'h7:    seg_out = 7'b1111000;
      4'h8:    seg_out = 7'b0000000;
      4'h9:    seg_out = 7'b0010000;
      4'hA:    seg_out = 7'b0001000;
      4'hB:    seg_out = 7'b0000011;
      4'hC:    seg_out = 7'b1000110;
      4'hD:    seg_out = 7'b0100001;
      4'hE:    seg_out = 7'b0000110;
      default: seg_out = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// Each digit is lit for DIV cycles, followed by BLANK_CYCLES all-dark cycles
// to avoid ghosting. Display data is captured once per frame so a frame
// never mixes old and new values.
//   clock_in   : sole clock, rising edge
//   reset      : synchronous, active-high
//   scan_en    : 0 forces blanking and freezes the digit index
//   data_in    : four hex nibbles, nibble i drives digit i
//   dp_in      : decimal point request per digit
//   digit_en   : per-digit enable, disabled digits stay dark
//   anode_out  : digit select, active-low
//   seg_out    : segments {g,f,e,d,c,b,a}, active-low
//   dp_out     : decimal point, active-low
//   frame_tick : one-cycle pulse when a new frame is loaded
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIV          = 65536,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                    clock_in,
  input  logic                    reset,
  input  logic                    scan_en,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   anode_out,
  output logic [SEG_W-1:0]        seg_out,
  output logic                    dp_out,
  output logic                    frame_tick
);

  localparam int MAX_CNT = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT);

  state_e                  state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] data_snap_q, data_snap_d;
  logic [NUM_DIGITS-1:0]   dp_snap_q, dp_snap_d;
  logic [NUM_DIGITS-1:0]   en_snap_q, en_snap_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [SEG_W-1:0]        seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    tick_q, tick_d;

  logic [3:0]       nibble;
  logic [SEG_W-1:0] seg_dec;
  logic             show_last;
  logic             blank_last;

  assign nibble     = data_snap_q[{idx_q, 2'b00} +: 4];
  assign show_last  = (cnt_q == CNT_W'(DIV - 1));
  assign blank_last = (cnt_q == CNT_W'(BLANK_CYCLES - 1));

  hex_to_7seg u_dec (
    .hex_in  (nibble),
    .seg_out (seg_dec)
  );

  // Next-state and output decode. Outputs are decoded from the current
  // state and registered, so the pins show the state of the previous cycle.
  always_comb begin
    // NOTE: every signal is given its hold/default value first so that no
    // path through the branches below leaves it unassigned (no latches).
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    data_snap_d = data_snap_q;
    dp_snap_d   = dp_snap_q;
    en_snap_d   = en_snap_q;
    tick_d      = 1'b0;
    anode_d     = '1;
    seg_d       = SEG_OFF;
    dp_d        = 1'b1;

    if (!scan_en) begin
      // Disable wins over any terminal count; idx is frozen.
      state_d = BLANK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SHOW: begin
          if (show_last) begin
            state_d = BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (blank_last) begin
            state_d = SHOW;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            // Wrapping back to digit 0 starts a frame: capture inputs here.
            if (idx_q == 2'd3) begin
              data_snap_d = data_in;
              dp_snap_d   = dp_in;
              en_snap_d   = digit_en;
              tick_d      = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end

    if (state_q == SHOW && en_snap_q[idx_q]) begin
      anode_d[idx_q] = 1'b0;
      seg_d          = seg_dec;
      dp_d           = ~dp_snap_q[idx_q];
    end
  end

  always_ff @(posedge clock_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= BLANK;
      idx_q       <= 2'd3;
      cnt_q       <= '0;
      // NOTE: the snapshots are storage, but they are reset too so the first
      // frame after reset never displays power-up garbage.
      data_snap_q <= '0;
      dp_snap_q   <= '0;
      en_snap_q   <= '0;
      anode_q     <= '1;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      data_snap_q <= data_snap_d;
      dp_snap_q   <= dp_snap_d;
      en_snap_q   <= en_snap_d;
      anode_q     <= anode_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      tick_q      <= tick_d;
    end
  end

  assign anode_out  = anode_q;
  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with DIV=4, BLANK_CYCLES=2.
// The reference model tracks a frame position 0..7 (even = digit p/2 lit,
// odd = blank gap after it) and a countdown of cycles left in that slot.
module tb_display_scan_ctrl;

  localparam int DIV   = 4;
  localparam int BLANK = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        scan_i = 1'b1;
  logic [15:0] data_i = 16'h3210;
  logic [3:0]  dp_i = 4'h0;
  logic [3:0]  en_i = 4'hF;
  logic [3:0]  anode_out;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic        frame_tick;

  int n_compared = 0;
  int n_failed   = 0;
  int cyc        = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(.DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .clock_in   (clk),
    .reset      (rst_i),
    .scan_en    (scan_i),
    .data_in    (data_i),
    .dp_in      (dp_i),
    .digit_en   (en_i),
    .anode_out  (anode_out),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .frame_tick (frame_tick)
  );

  // ---------------- reference model ----------------
  int          m_pos = 7;
  int          m_rem = BLANK;
  logic [15:0] m_data = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_en = '0;
  logic [12:0] exp_view;   // {anode, seg, dp}
  logic        exp_tick;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  function automatic logic [12:0] view_of(input int p);
    int         d;
    logic [3:0] an;
    d = p / 2;
    if (p % 2 == 0 && m_en[d]) begin
      an = 4'hF;
      an[d] = 1'b0;
      return {an, seg_of(m_data[4*d +: 4]), ~m_dp[d]};
    end
    return {4'hF, 7'h7F, 1'b1};
  endfunction

  task automatic model_edge();
    if (rst_i) begin
      m_pos = 7; m_rem = BLANK;
      m_data = '0; m_dp = '0; m_en = '0;
      exp_view = {4'hF, 7'h7F, 1'b1};
      exp_tick = 1'b0;
      return;
    end
    exp_view = view_of(m_pos);
    exp_tick = 1'b0;
    if (!scan_i) begin
      if (m_pos % 2 == 0) m_pos = m_pos + 1;
      m_rem = BLANK;
    end else begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_pos = (m_pos + 1) % 8;
        m_rem = (m_pos % 2 == 0) ? DIV : BLANK;
        if (m_pos == 0) begin
          m_data = data_i; m_dp = dp_i; m_en = en_i;
          exp_tick = 1'b1;
        end
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_compared++;
    if (act !== req) begin
      n_failed++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock: DUT and model both see the inputs set before the edge;
  // outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("model", {19'd0, anode_out, seg_out, dp_out, frame_tick}, {19'd0, exp_view, exp_tick});
  endtask

  task automatic wait_anode(input logic [3:0] v, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      if (anode_out == v) found = 1'b1;
    end
    check({"reach_", name}, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_tick(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      if (frame_tick) found = 1'b1;
    end
    check({"tick_", name}, {31'd0, found}, 32'd1);
  endtask

  typedef struct {
    logic        rst;
    logic        scan;
    logic [15:0] data;
    logic [3:0]  en;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dpo;
    logic        tick;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [3:0] an, input logic [6:0] sg, input logic tk);
    vec_t v;
    v.rst = r; v.scan = 1'b1; v.data = 16'h3210; v.en = 4'hF;
    v.anode = an; v.seg = sg; v.dpo = 1'b1; v.tick = tk;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    int   lo_cnt [4];
    int   period;
    int   lit02, lit1, lit3, dp1_low, dp3_high;
    bit   seen;

    // Reset release sequence: tick two cycles after release, then digit 0.
    vecs[0] = mk(1'b1, 4'hF, 7'h7F, 1'b0);
    vecs[1] = mk(1'b0, 4'hF, 7'h7F, 1'b0);
    vecs[2] = mk(1'b0, 4'hF, 7'h7F, 1'b1);
    for (int i = 3; i < 7; i++) vecs[i] = mk(1'b0, 4'b1110, 7'b1000000, 1'b0);
    vecs[7] = mk(1'b0, 4'hF, 7'h7F, 1'b0);
    vecs[8] = mk(1'b0, 4'hF, 7'h7F, 1'b0);
    vecs[9] = mk(1'b0, 4'b1101, 7'b1111001, 1'b0);

    for (int i = 0; i < 10; i++) begin
      rst_i = vecs[i].rst; scan_i = vecs[i].scan;
      data_i = vecs[i].data; en_i = vecs[i].en; dp_i = 4'h0;
      step();
      check($sformatf("vec%0d", i), {19'd0, anode_out, seg_out, dp_out, frame_tick},
            {19'd0, vecs[i].anode, vecs[i].seg, vecs[i].dpo, vecs[i].tick});
    end

    // Steady run: frame period and per-digit on-time.
    wait_tick("period_start");
    for (int i = 0; i < 4; i++) lo_cnt[i] = 0;
    period = 0;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      step();
      period++;
      if (frame_tick) seen = 1'b1;
      else for (int d = 0; d < 4; d++) if (!anode_out[d]) lo_cnt[d]++;
    end
    check("frame_period", period, 24);
    // The closing tick cycle still shows the last blank, so the four lit
    // windows were all counted in the preceding 23 cycles.
    for (int d = 0; d < 4; d++) check($sformatf("anode%0d_low", d), lo_cnt[d], 4);

    // Mid-frame data change must not tear the current frame.
    wait_anode(4'b1101, "d1");
    data_i = 16'hFFFF;
    wait_anode(4'b1011, "d2_old");
    check("old_digit2", seg_out, 7'b0100100);
    wait_anode(4'b0111, "d3_old");
    check("old_digit3", seg_out, 7'b0110000);
    wait_anode(4'b1110, "d0_new");
    check("new_digit0", seg_out, 7'b0001110);
    wait_anode(4'b1101, "d1_new");
    check("new_digit1", seg_out, 7'b0001110);

    // Digit enables and decimal points.
    data_i = 16'h3210; en_i = 4'b1010; dp_i = 4'b0010;
    wait_tick("en_load");
    lit02 = 0; lit1 = 0; lit3 = 0; dp1_low = 0; dp3_high = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (!anode_out[0] || !anode_out[2]) lit02++;
      if (anode_out == 4'b1101) begin lit1++; if (!dp_out) dp1_low++; end
      if (anode_out == 4'b0111) begin lit3++; if (dp_out) dp3_high++; end
    end
    check("dark_digits", lit02, 0);
    check("digit1_lit", lit1, 4);
    check("digit1_dp_on", dp1_low, 4);
    check("digit3_lit", lit3, 4);
    check("digit3_dp_off", dp3_high, 4);

    // scan_en dropped during SHOW of digit 1.
    en_i = 4'hF; dp_i = 4'h0;
    wait_tick("scan_load");
    wait_anode(4'b1101, "scan_d1");
    step();
    scan_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i > 0) check($sformatf("scan_off%0d", i), {28'd0, anode_out}, 32'hF);
    end
    scan_i = 1'b1;
    step();
    check("resume_blank0", {28'd0, anode_out}, 32'hF);
    step();
    check("resume_blank1", {28'd0, anode_out}, 32'hF);
    step();
    check("resume_digit2", {28'd0, anode_out}, 32'hB);

    // Reset in the middle of digit 2.
    wait_anode(4'b1011, "rst_d2");
    rst_i = 1'b1;
    step();
    check("rst_dark", {19'd0, anode_out, seg_out, dp_out, frame_tick}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    rst_i = 1'b0;
    step();
    check("rst_tick_early", {31'd0, frame_tick}, 32'd0);
    step();
    check("rst_tick", {31'd0, frame_tick}, 32'd1);
    step();
    check("rst_digit0", {28'd0, anode_out}, 32'hE);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst_i = ($urandom_range(0, 199) == 0);
      if (!scan_i) scan_i = ($urandom_range(0, 1) == 0);
      else         scan_i = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 5) == 0) data_i = 16'($urandom);
      if ($urandom_range(0, 9) == 0) dp_i = 4'($urandom);
      if ($urandom_range(0, 9) == 0) en_i = 4'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
